// File: rtl/sdram_chip_responder.sv
// Behavioural SDRAM device (MT48LC16M16 command set) for controller loopback benches.
// It decodes commands, tracks bank state and timing, stores data in byte-wide RAM, and flags protocol errors.
module sdram_chip_responder #(
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 9,
    parameter int RCD      = 2,
    parameter int RP       = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_dqm,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic [1:0]  sd_dq_oe,
    output logic        init_done,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH    = 1 << IDX_BITS;
    localparam int TW       = 4;
    // A timer loaded with N-1 reaches zero in time for a command issued N cycles later.
    localparam logic [TW-1:0] RCD_LD = TW'(RCD - 1);
    localparam logic [TW-1:0] RP_LD  = TW'(RP - 1);

    typedef enum logic [3:0] {
        CMD_INHIBIT, CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE,
        CMD_BST, CMD_PRE, CMD_REF, CMD_LMR
    } cmd_e;

    typedef enum logic {BANK_IDLE, BANK_OPEN} bank_state_e;

    cmd_e cmd;

    bank_state_e             bank_st_q  [4];
    bank_state_e             bank_st_d  [4];
    logic [ROW_BITS-1:0]     bank_row_q [4];
    logic [ROW_BITS-1:0]     bank_row_d [4];
    logic [TW-1:0]           bank_tmr_q [4];
    logic [TW-1:0]           bank_tmr_d [4];

    logic        init_done_q, init_done_d;
    logic [12:0] mode_reg_q, mode_reg_d;
    logic [15:0] refresh_cnt_q, refresh_cnt_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;

    logic        rd0_vld_q, rd0_vld_d;
    logic        rd0_cl3_q, rd0_cl3_d;
    logic [1:0]  rd0_be_q, rd0_be_d;
    logic        rd1_vld_q, rd1_vld_d;
    logic [1:0]  rd1_be_q, rd1_be_d;
    logic [15:0] rd1_data_q, rd1_data_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic [1:0]  dq_oe_q, dq_oe_d;

    logic [7:0]          mem_lo [DEPTH];
    logic [7:0]          mem_hi [DEPTH];
    logic [15:0]         ram_rd_q;
    logic [IDX_BITS-1:0] mem_idx;
    logic [1:0]          mem_wr_be;
    logic                rd_issue;
    logic                any_open;
    logic [7:1]          viol;
    logic [2:0]          viol_code;

    always_comb begin
        if (sd_cs) begin
            cmd = CMD_INHIBIT;
        end else begin
            unique case ({sd_ras, sd_cas, sd_we})
                3'b111:  cmd = CMD_NOP;
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b110:  cmd = CMD_BST;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                default: cmd = CMD_LMR;
            endcase
        end
    end

    assign mem_idx = {sd_ba, bank_row_q[sd_ba], sd_addr[COL_BITS-1:0]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        for (int b = 0; b < 4; b++) begin
            bank_st_d[b]  = bank_st_q[b];
            bank_row_d[b] = bank_row_q[b];
            bank_tmr_d[b] = (bank_tmr_q[b] != '0) ? bank_tmr_q[b] - TW'(1) : '0;
        end
        init_done_d   = init_done_q;
        mode_reg_d    = mode_reg_q;
        refresh_cnt_d = refresh_cnt_q;
        mem_wr_be     = 2'b00;
        rd_issue      = 1'b0;
        viol          = '0;
        any_open      = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (bank_st_q[b] == BANK_OPEN) any_open = 1'b1;
        end

        unique case (cmd)
            CMD_ACT: begin
                if (!init_done_q) begin
                    viol[7] = 1'b1;
                end else begin
                    if (bank_st_q[sd_ba] == BANK_OPEN) viol[1] = 1'b1;
                    if (bank_tmr_q[sd_ba] != '0)       viol[2] = 1'b1;
                    bank_st_d[sd_ba]  = BANK_OPEN;
                    bank_row_d[sd_ba] = sd_addr[ROW_BITS-1:0];
                    bank_tmr_d[sd_ba] = RCD_LD;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!init_done_q) begin
                    viol[7] = 1'b1;
                end else begin
                    if (bank_st_q[sd_ba] == BANK_IDLE)          viol[3] = 1'b1;
                    if (bank_tmr_q[sd_ba] != '0)                viol[2] = 1'b1;
                    if (cmd == CMD_WRITE && dq_oe_q != 2'b00)   viol[4] = 1'b1;
                    if (sd_addr[10]) begin
                        bank_st_d[sd_ba]  = BANK_IDLE;
                        bank_tmr_d[sd_ba] = RP_LD;
                    end
                    if (cmd == CMD_READ) rd_issue  = 1'b1;
                    else                 mem_wr_be = ~sd_dqm;
                end
            end
            CMD_PRE: begin
                for (int b = 0; b < 4; b++) begin
                    if ((sd_addr[10] || sd_ba == 2'(b)) && bank_st_q[b] == BANK_OPEN) begin
                        bank_st_d[b]  = BANK_IDLE;
                        bank_tmr_d[b] = RP_LD;
                    end
                end
            end
            CMD_REF: begin
                if (any_open)                        viol[5] = 1'b1;
                else if (refresh_cnt_q != 16'hFFFF)  refresh_cnt_d = refresh_cnt_q + 16'd1;
            end
            CMD_LMR: begin
                if (any_open) viol[5] = 1'b1;
                if (sd_addr[2:0] != 3'b000 || !(sd_addr[6:4] inside {3'd2, 3'd3})) viol[6] = 1'b1;
                mode_reg_d  = sd_addr;
                init_done_d = 1'b1;
            end
            default: ;
        endcase

        viol_code = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (viol[i]) viol_code = 3'(i);
        end
        err_d      = err_q;
        err_code_d = err_code_q;
        if (!err_q && viol != '0) begin
            err_d      = 1'b1;
            err_code_d = viol_code;
        end
    end

    // Read return: CL2 drives from stage 0, CL3 passes through stage 1 and takes its DQM one cycle later.
    always_comb begin
        rd0_vld_d  = rd_issue;
        rd0_cl3_d  = (mode_reg_q[6:4] == 3'd3);
        rd0_be_d   = ~sd_dqm;
        rd1_vld_d  = rd0_vld_q && rd0_cl3_q;
        rd1_be_d   = ~sd_dqm;
        rd1_data_d = ram_rd_q;
        dq_oe_d    = 2'b00;
        dq_out_d   = 16'h0000;
        if (rd1_vld_q) begin
            dq_oe_d  = rd1_be_q;
            dq_out_d = rd1_data_q & {{8{rd1_be_q[1]}}, {8{rd1_be_q[0]}}};
        end else if (rd0_vld_q && !rd0_cl3_q) begin
            dq_oe_d  = rd0_be_q;
            dq_out_d = ram_rd_q & {{8{rd0_be_q[1]}}, {8{rd0_be_q[0]}}};
        end
    end

    // NOTE: the storage array has no reset; only control state is cleared, so data survives reset.
    always_ff @(posedge clk) begin
        if (mem_wr_be[0]) mem_lo[mem_idx] <= sd_dq_in[7:0];
        if (mem_wr_be[1]) mem_hi[mem_idx] <= sd_dq_in[15:8];
        if (rd_issue)     ram_rd_q        <= {mem_hi[mem_idx], mem_lo[mem_idx]};
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 4; b++) begin
                bank_st_q[b]  <= BANK_IDLE;
                bank_row_q[b] <= '0;
                bank_tmr_q[b] <= '0;
            end
            init_done_q   <= 1'b0;
            mode_reg_q    <= '0;
            refresh_cnt_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            rd0_vld_q     <= 1'b0;
            rd0_cl3_q     <= 1'b0;
            rd0_be_q      <= '0;
            rd1_vld_q     <= 1'b0;
            rd1_be_q      <= '0;
            rd1_data_q    <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                bank_st_q[b]  <= bank_st_d[b];
                bank_row_q[b] <= bank_row_d[b];
                bank_tmr_q[b] <= bank_tmr_d[b];
            end
            init_done_q   <= init_done_d;
            mode_reg_q    <= mode_reg_d;
            refresh_cnt_q <= refresh_cnt_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            rd0_vld_q     <= rd0_vld_d;
            rd0_cl3_q     <= rd0_cl3_d;
            rd0_be_q      <= rd0_be_d;
            rd1_vld_q     <= rd1_vld_d;
            rd1_be_q      <= rd1_be_d;
            rd1_data_q    <= rd1_data_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
        end
    end

    assign sd_dq_out   = dq_out_q;
    assign sd_dq_oe    = dq_oe_q;
    assign init_done   = init_done_q;
    assign mode_reg    = mode_reg_q;
    assign refresh_cnt = refresh_cnt_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
